// File: rtl/norm_arbiter.sv
// rtl/norm_arbiter.sv - round-robin sharing of one zero_count normalizer with in-order, credit-protected responses
module norm_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int WIDTH   = 24,
  parameter int WIDTHR  = 5,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [WIDTH-1:0]         zc_data,
  input  logic [WIDTHR-1:0]        zc_distance,
  input  logic [WIDTH-1:0]         zc_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTHR-1:0]        rsp_distance,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + WIDTHR + WIDTH + 1;

  logic [ID_W-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_zc_data;
  logic [LATENCY:0]   r_tag_v;
  logic [LATENCY:0]   r_tag_zero;
  logic [ID_W-1:0]    r_tag_id [LATENCY+1];
  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_credit;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_credit_ok;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_in_flight;

  // credit counts every op from grant until it leaves the FIFO, so a push can never find it full
  assign w_credit_ok = r_credit < CW'(DEPTH);

  // scanning from the far end lets the requester closest to the pointer win by overwriting
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_idx    = '0;
    if (w_credit_ok) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
        if (req_valid[w_idx]) begin
          w_grant        = '0;
          w_grant[w_idx] = 1'b1;
          w_gnt_id       = w_idx;
        end
      end
    end
  end

  assign req_ready  = w_grant;
  assign w_issue    = |w_grant;
  assign w_gnt_data = req_data[w_gnt_id*WIDTH +: WIDTH];
  assign w_ptr_next = (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + 1'b1;
  assign zc_data    = r_zc_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_zc_data  <= '0;
      r_tag_v    <= '0;
      r_tag_zero <= '0;
      for (int s = 0; s <= LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      if (w_issue) begin
        r_ptr     <= w_ptr_next;
        r_zc_data <= w_gnt_data;
      end
      for (int s = LATENCY; s > 0; s--) begin
        r_tag_v[s]    <= r_tag_v[s-1];
        r_tag_zero[s] <= r_tag_zero[s-1];
        r_tag_id[s]   <= r_tag_id[s-1];
      end
      r_tag_v[0]    <= w_issue;
      r_tag_zero[0] <= (w_gnt_data == '0);
      r_tag_id[0]   <= w_gnt_id;
    end
  end

  // the last tag stage lines up with the unit's output for the same operand
  assign w_push    = r_tag_v[LATENCY];
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= '0;
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_tag_id[LATENCY], zc_distance, zc_result, r_tag_zero[LATENCY]};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_credit <= r_credit + CW'(w_issue) - CW'(w_pop);
    end
  end

  assign {rsp_id, rsp_distance, rsp_result, rsp_zero} = r_mem[r_rd_ptr];

  assign w_in_flight = CW'($countones(r_tag_v));

  a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(req_ready));
  a_no_push_full:  assert property (@(posedge clock) disable iff (!reset_n) w_push |-> (r_count != CW'(DEPTH)));
  a_no_pop_empty:  assert property (@(posedge clock) disable iff (!reset_n) w_pop |-> (r_count != '0));
  a_credit_bound:  assert property (@(posedge clock) disable iff (!reset_n)
                                    ((w_in_flight + r_count) == r_credit) && (r_credit <= CW'(DEPTH)));

endmodule
